// File: rtl/tetromino_bag_queue.sv
// tetromino_bag_queue
// Piece-sequence generator: a 32-bit Galois LFSR feeds a candidate picker,
// which pushes one piece at a time into a small circular FIFO exposing the
// current piece and a flattened preview window.
// Optional feature macro: TETROMINO_BAG_EN
//   defined   -> N-bag shuffle (used-mask with linear probe, auto refill)
//   undefined -> candidate pushed directly, repeats allowed
module tetromino_bag_queue #(
    parameter int          NUM_PIECES    = 7,
    parameter int          PIECE_W       = 3,
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [31:0] SEED          = 32'h55555555
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               take,
    input  logic                               reseed,
    input  logic [31:0]                        seed,
    output logic [PIECE_W-1:0]                 piece,
    output logic                               piece_valid,
    output logic [PREVIEW_DEPTH*PIECE_W-1:0]   preview,
    output logic [$clog2(PREVIEW_DEPTH+2)-1:0] fill_count
);

    localparam int unsigned Q     = PREVIEW_DEPTH + 1;
    localparam int          CNT_W = $clog2(PREVIEW_DEPTH + 2);
    localparam int          PTR_W = (Q > 1) ? $clog2(Q) : 1;

    localparam logic [31:0]        LFSR_MASK = 32'h80200003;
    localparam logic [CNT_W-1:0]   Q_CNT     = CNT_W'(Q);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(Q - 1);
    localparam logic [PIECE_W:0]   NUM_WIDE  = (PIECE_W+1)'(NUM_PIECES);
    localparam logic [PIECE_W-1:0] NUM_NARROW = PIECE_W'(NUM_PIECES);
    localparam logic [PIECE_W-1:0] CAND_LAST = PIECE_W'(NUM_PIECES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PICK,
        DEAL
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        lfsr_q, lfsr_d;
    logic [PIECE_W-1:0] cand_q, cand_d;
    logic [PIECE_W-1:0] fifo_q [Q];
    logic [PIECE_W-1:0] fifo_d [Q];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
`ifdef TETROMINO_BAG_EN
    logic [NUM_PIECES-1:0] used_q, used_d;
    logic [NUM_PIECES-1:0] cand_bit;
    logic [NUM_PIECES-1:0] used_set;
`endif

    logic [PIECE_W-1:0] cand_raw;
    logic [PIECE_W-1:0] cand_new;
    logic               pop;
    logic               push;

    // Advance a FIFO pointer by an offset, wrapping at the queue depth.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                 input int unsigned      off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= Q) begin
            s = s - Q;
        end
        return PTR_W'(s);
    endfunction

    // Next-state logic for the LFSR, picker FSM, bag mask and FIFO pointers;
    // reseed overrides everything and restarts from a reset-equivalent state.
    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
        state_d  = state_q;
        cand_d   = cand_q;
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
`ifdef TETROMINO_BAG_EN
        used_d   = used_q;
        cand_bit = '0;
        cand_bit[cand_q] = 1'b1;
        used_set = used_q | cand_bit;
`endif

        cand_raw = lfsr_q[PIECE_W-1:0];
        cand_new = ({1'b0, cand_raw} >= NUM_WIDE) ? (cand_raw - NUM_NARROW) : cand_raw;

        pop  = take && (count_q != '0);
        push = (state_q == DEAL);

        case (state_q)
            IDLE: begin
                if ((count_q < Q_CNT) || (pop && (count_q == Q_CNT))) begin
                    state_d = PICK;
                    cand_d  = cand_new;
                end
            end
            PICK: begin
`ifdef TETROMINO_BAG_EN
                if (!used_q[cand_q]) begin
                    used_d  = (&used_set) ? '0 : used_set;
                    state_d = DEAL;
                end else begin
                    cand_d = (cand_q == CAND_LAST) ? '0 : cand_q + 1'b1;
                end
`else
                state_d = DEAL;
`endif
            end
            DEAL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push) begin
            fifo_d[wr_ptr_q] = cand_q;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (reseed) begin
            lfsr_d   = (seed != 32'h0) ? seed : SEED;
            state_d  = IDLE;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
`ifdef TETROMINO_BAG_EN
            used_d   = '0;
`endif
        end
    end

    // All generator and queue state, cleared asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q   <= SEED;
            state_q  <= IDLE;
            cand_q   <= '0;
            fifo_q   <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
`ifdef TETROMINO_BAG_EN
            used_q   <= '0;
`endif
        end else begin
            lfsr_q   <= lfsr_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            fifo_q   <= fifo_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
`ifdef TETROMINO_BAG_EN
            used_q   <= used_d;
`endif
        end
    end

    // Output decode from registered FIFO state; empty slots read as zero.
    always_comb begin
        fill_count  = count_q;
        piece_valid = (count_q != '0);
        piece       = piece_valid ? fifo_q[rd_ptr_q] : '0;
        preview     = '0;
        for (int k = 0; k < PREVIEW_DEPTH; k++) begin
            if (int'(count_q) > k + 1) begin
                preview[k*PIECE_W +: PIECE_W] = fifo_q[ptr_add(rd_ptr_q, 32'(k + 1))];
            end
        end
    end

endmodule

// File: doc/tetromino_bag_queue.md
# tetromino_bag_queue

Parametrised piece-sequence generator for the falling-block game core. A 32-bit Galois LFSR drives an optional N-bag shuffle, which deals pieces into a small FIFO. The FIFO presents the current piece plus a flattened preview window to the game FSM and the next-piece display. It replaces the single-register random piece source and adds bag fairness, preview lookahead, a take handshake and runtime reseeding.

## Interface
- NUM_PIECES, 7: number of distinct piece codes, 2..2^PIECE_W; legal codes are 0..NUM_PIECES-1.
- PIECE_W, 3: piece code width; must equal clog2(NUM_PIECES).
- PREVIEW_DEPTH, 3: preview slots after the current piece; FIFO depth Q = PREVIEW_DEPTH+1.
- SEED, 32'h55555555: LFSR reset value; must be non-zero.
- clk  in  1: system clock, all state on rising edge.
- rst  in  1: asynchronous, active-high reset.
- take  in  1: consumer pops the current piece; acts only when piece_valid=1.
- reseed  in  1: one-cycle strobe; loads seed and restarts the sequence.
- seed  in  32: reseed value; 0 substitutes SEED.
- piece  out  PIECE_W: head of FIFO (current piece); 0 when empty.
- piece_valid  out  1: FIFO holds at least one entry.
- preview  out  PREVIEW_DEPTH*PIECE_W: slot k occupies bits [k*PIECE_W +: PIECE_W] and holds FIFO entry k+1; unused slots read 0.
- fill_count  out  clog2(Q+1): number of FIFO entries.

## Operation
- LFSR: 32-bit Galois, right shift, feedback mask 32'h80200003. Advances every cycle except the reset/reseed load cycle.
- Candidate: c = lfsr[PIECE_W-1:0]; if c >= NUM_PIECES, c = c - NUM_PIECES. One subtraction always suffices.
- FSM states:
  - IDLE: enter PICK when fill_count < Q, or when a take pops in the same cycle as the FIFO being full.
  - PICK: resolve one piece and push it.
  - DEAL: one-cycle push, then back to IDLE.
- On entry to PICK, register cand = c.
- Bag mode: each cycle in PICK tests used[cand].
  - If clear: set used[cand] and go to DEAL.
  - If set: cand = (cand+1) mod NUM_PIECES and stay in PICK.
- Bag refill: the push that makes used all-ones clears used to 0 in the same cycle. Every aligned group of NUM_PIECES pushes after reset/reseed is therefore a permutation of 0..NUM_PIECES-1.
- FIFO: circular buffer with read/write pointers wrapping at Q.
  - take && piece_valid pops the head.
  - Push and pop in the same cycle both occur; fill_count is unchanged.
  - A push is never issued when fill_count = Q and no pop is occurring.
- reseed: next edge loads lfsr = (seed ? seed : SEED), flushes the FIFO, clears used and forces IDLE. It has priority over take and over any in-flight PICK/DEAL; the in-flight piece is discarded.
- take with piece_valid=0 is ignored.

## Timing
- Reset values: lfsr=SEED, used=0, FIFO empty, piece=0, piece_valid=0, preview=0, fill_count=0, FSM=IDLE.
- All outputs are registered or decoded from registered state; none depends combinationally on take.
- Per-piece latency, PICK entry to pushed entry visible at outputs:
  - Bag mode: 2..NUM_PIECES+1 cycles.
  - Non-bag mode: exactly 2 cycles.
- Initial fill from reset deassertion takes at most Q*(NUM_PIECES+2) cycles; with defaults, at most 36.
- After a pop, piece shows the former preview slot 0 on the next cycle. The refilled tail appears after the per-piece latency.

## Configuration
- TETROMINO_BAG_EN defined: bag mode as described, with used register and linear probe.
- TETROMINO_BAG_EN undefined:
  - No used register; PICK always takes one cycle and pushes cand directly.
  - Sequence is uniform-ish random with repeats allowed.
  - All other behaviour and the interface are identical.

## Test plan
- Defaults, bag on: release rst, hold take=0 -> fill_count reaches 4 within 36 cycles, piece_valid=1, all codes < 7.
- Bag on, take every cycle piece_valid=1 for 70 pieces -> each group of 7 consecutive pieces from the first is a permutation of 0..6.
- Full FIFO, single take pulse -> that cycle fill_count stays 4 after refill, and the piece after the edge equals the prior preview[2:0].
- reseed with seed=0 mid-PICK -> next cycle fill_count=0, piece_valid=0. Sequence is identical to the post-reset sequence from SEED.
- Bag off, 1000 takes -> every piece < 7, at least one immediate repeat observed, each pick latency exactly 2 cycles.
- take held with FIFO empty -> no pointer change, fill_count rises normally, and no underflow occurs.
